// File: rtl/count_seq_checker_if.sv
// Interface bundling the counter-stream sample inputs and the checker status outputs.
// The master side is the counter stream source; the slave side is the checker.
interface count_seq_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_count;
    logic             err_clr;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] expected;

    modport master (
        output in_valid,
        output in_count,
        output err_clr,
        input  locked,
        input  err_pulse,
        input  err_count,
        input  expected
    );

    modport slave (
        input  in_valid,
        input  in_count,
        input  err_clr,
        output locked,
        output err_pulse,
        output err_count,
        output expected
    );
endinterface

// File: rtl/count_seq_checker.sv
// Receive-side checker for a free-running up-counter stream.
// Hunts for LOCK_CNT consecutive correct increments, then tracks the stream with a
// flywheel: isolated bad samples are counted but the reference keeps advancing on its
// own. LOSS_CNT consecutive misses while locked drop back to hunting, re-referenced
// on the sample that caused the loss.
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    count_seq_checker_if.slave   bus
);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Counter widths hold values up to the thresholds themselves.
    localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int SW = (LOSS_CNT < 2) ? 1 : $clog2(LOSS_CNT + 1);

    localparam logic [WIDTH-1:0] CNT_ONE  = 1;
    localparam logic [MW-1:0]    M_ONE    = 1;
    localparam logic [SW-1:0]    S_ONE    = 1;
    localparam logic [ERR_W-1:0] ERR_ONE  = 1;
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [MW-1:0]    LOCK_TGT = MW'(LOCK_CNT);
    localparam logic [SW-1:0]    LOSS_TGT = SW'(LOSS_CNT);

    logic [0:0]       state;
    logic             ref_valid;
    logic [MW-1:0]    match_cnt;
    logic [SW-1:0]    miss_cnt;
    logic [WIDTH-1:0] expected_r;
    logic [ERR_W-1:0] err_count_r;
    logic             err_pulse_r;
    logic             locked_r;

    logic             sample_ok;
    logic [MW-1:0]    match_inc;
    logic [SW-1:0]    miss_inc;
    logic [WIDTH-1:0] sample_next;
    logic [WIDTH-1:0] flywheel_next;
    logic [ERR_W-1:0] err_base;
    logic [ERR_W-1:0] err_inc;

    // Next-value helpers shared by both states; err_clr zeroes the base so a
    // same-cycle mismatch lands on exactly one.
    always_comb begin
        sample_ok     = (bus.in_count == expected_r);
        match_inc     = match_cnt + M_ONE;
        miss_inc      = miss_cnt + S_ONE;
        sample_next   = bus.in_count + CNT_ONE;
        flywheel_next = expected_r + CNT_ONE;
        err_base      = bus.err_clr ? '0 : err_count_r;
        err_inc       = (err_base == ERR_MAX) ? ERR_MAX : err_base + ERR_ONE;
    end

    // Hunt/lock state machine with flywheel tracking and saturating error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_HUNT;
            ref_valid   <= 1'b0;
            match_cnt   <= '0;
            miss_cnt    <= '0;
            expected_r  <= '0;
            err_count_r <= '0;
            err_pulse_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            err_pulse_r <= 1'b0;
            if (bus.err_clr) begin
                err_count_r <= '0;
            end
            if (bus.in_valid) begin
                case (state)
                    ST_HUNT: begin
                        expected_r <= sample_next;
                        if (!ref_valid) begin
                            ref_valid <= 1'b1;
                            match_cnt <= '0;
                        end else if (sample_ok) begin
                            if (match_inc == LOCK_TGT) begin
                                state     <= ST_LOCKED;
                                locked_r  <= 1'b1;
                                miss_cnt  <= '0;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_inc;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    default: begin
                        if (sample_ok) begin
                            miss_cnt   <= '0;
                            expected_r <= flywheel_next;
                        end else begin
                            err_pulse_r <= 1'b1;
                            err_count_r <= err_inc;
                            if (miss_inc == LOSS_TGT) begin
                                state      <= ST_HUNT;
                                locked_r   <= 1'b0;
                                match_cnt  <= '0;
                                miss_cnt   <= '0;
                                ref_valid  <= 1'b1;
                                expected_r <= sample_next;
                            end else begin
                                miss_cnt   <= miss_inc;
                                expected_r <= flywheel_next;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.locked    = locked_r;
    assign bus.err_pulse = err_pulse_r;
    assign bus.err_count = err_count_r;
    assign bus.expected  = expected_r;

endmodule
